pingpong_read_sched: RTL

Read-side scheduler for the two-bank (ping-pong) matrix buffer. It tracks which bank the write side has filled. For the oldest full bank it generates read addresses for eight bit-plane passes, with row sync and the 3-bit mux select. When the matrix is consumed it releases the bank back to the writer. It sits between the bank write controller and the 1:8 bit-select mux / serializer downstream.

---
 rtl/pingpong_read_sched_pkg.sv | 22 ++
 rtl/pingpong_bank_flags.sv | 34 +++
 rtl/pingpong_read_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pingpong_read_sched_pkg.sv
// Shared constants for the ping-pong matrix read scheduler: FSM state codes,
// bit-plane count and default geometry.
package pingpong_read_sched_pkg;

  localparam int NUM_PLANES  = 8;
  localparam int PLANE_W     = 3;
  localparam int DEF_ROWS    = 64;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_GAP_CYC = 2;

  // Scheduler states, kept as plain codes so legacy tooling can decode them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  // Counter width for a counter holding values 0..n-1, never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pingpong_bank_flags.sv
// Full flags for the two matrix banks plus the sticky overflow error.
// A writer-done set always wins over a reader release of the same bank.
module pingpong_bank_flags (
  input  logic       SYS_CLK,
  input  logic       SYS_RST,
  input  logic       set_vld,
  input  logic       set_bank,
  input  logic       clr_vld,
  input  logic       clr_bank,
  output logic [1:0] full,
  output logic       err_ovf
);

  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  assign set_mask = {set_vld & set_bank, set_vld & ~set_bank};
  assign clr_mask = {clr_vld & clr_bank, clr_vld & ~clr_bank};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      full    <= 2'b00;
      err_ovf <= 1'b0;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
      if (set_vld && full[set_bank]) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pingpong_read_sched.sv
// Read-side scheduler for the two-bank matrix buffer: walks eight bit-plane
// passes over the oldest full bank, then hands the bank back to the writer.
module pingpong_read_sched
  import pingpong_read_sched_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              WR_DONE_I,
  input  logic              WR_BANK_I,
  input  logic              RD_READY_I,
  output logic [1:0]        BANK_FULL_O,
  output logic [ADDR_W-1:0] RADDR_O,
  output logic              RADDR_VLD_O,
  output logic              RADDR_HSYNC_O,
  output logic              RD_BANK_O,
  output logic [2:0]        CTRL_BIT_SEL_O,
  output logic              READ_ONE_MATRIX_O,
  output logic              ERR_OVF_O
);

  localparam int                   GAP_W      = cnt_width(GAP_CYC + 1);
  localparam logic [ADDR_W-1:0]    ADDR_LAST  = ADDR_W'(ROWS - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PLANE_W-1:0]   PLANE_LAST = PLANE_W'(NUM_PLANES - 1);

  state_t               state_q,   state_d;
  logic [ADDR_W-1:0]    addr_q,    addr_d;
  logic [PLANE_W-1:0]   bit_sel_q, bit_sel_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 rd_ptr_q,  rd_ptr_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 vld_q;
  logic                 hsync_q;
  logic                 matrix_done_q;
  logic                 xfer;
  logic                 release_now;
  logic [1:0]           bank_full;

  pingpong_bank_flags u_flags (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST  (SYS_RST),
    .set_vld  (WR_DONE_I),
    .set_bank (WR_BANK_I),
    .clr_vld  (release_now),
    .clr_bank (rd_ptr_q),
    .full     (bank_full),
    .err_ovf  (ERR_OVF_O)
  );

  assign xfer = vld_q & RD_READY_I;

  // NOTE: every always_comb output gets a default on entry, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bit_sel_d   = bit_sel_q;
    gap_cnt_d   = gap_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_bank_d   = rd_bank_q;
    release_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bank_full[rd_ptr_q]) begin
          state_d   = ST_READ;
          addr_d    = '0;
          bit_sel_d = '0;
          rd_bank_d = rd_ptr_q;
        end
      end

      ST_READ: begin
        if (xfer) begin
          if (addr_q == ADDR_LAST) begin
            addr_d = '0;
            if (bit_sel_q == PLANE_LAST) begin
              // Last row of the last plane: the matrix is consumed.
              release_now = 1'b1;
              bit_sel_d   = '0;
              rd_ptr_d    = ~rd_ptr_q;
              state_d     = ST_IDLE;
            end else begin
              bit_sel_d = bit_sel_q + 1'b1;
              if (GAP_CYC > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
              end
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_READ;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Valid and hsync are registered from next-state values so they line up
  // with the address they qualify.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      bit_sel_q     <= '0;
      gap_cnt_q     <= '0;
      rd_ptr_q      <= 1'b0;
      rd_bank_q     <= 1'b0;
      vld_q         <= 1'b0;
      hsync_q       <= 1'b0;
      matrix_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      bit_sel_q     <= bit_sel_d;
      gap_cnt_q     <= gap_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_bank_q     <= rd_bank_d;
      vld_q         <= (state_d == ST_READ);
      hsync_q       <= (state_d == ST_READ) && (addr_d == '0);
      matrix_done_q <= release_now;
    end
  end

  assign BANK_FULL_O       = bank_full;
  assign RADDR_O           = addr_q;
  assign RADDR_VLD_O       = vld_q;
  assign RADDR_HSYNC_O     = hsync_q;
  assign RD_BANK_O         = rd_bank_q;
  assign CTRL_BIT_SEL_O    = bit_sel_q;
  assign READ_ONE_MATRIX_O = matrix_done_q;

endmodule
